// File: rtl/adder_operand_sequencer.sv
// Operand sequencer for a parallel adder. It gathers A and B (with carry-in) from a byte stream,
// drives the adder, captures the sum after ADD_LATENCY cycles and returns it on a result stream.
module adder_operand_sequencer #(
  parameter int WIDTH       = 8,
  parameter int ADD_LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       op_count,
  output logic             busy
);

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [3:0] LAT = 4'(ADD_LATENCY);

  logic [1:0]       state_q, state_d;
  logic [3:0]       timer_q, timer_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_cout_q, res_cout_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       op_count_q, op_count_d;

  logic in_xfer, res_xfer;

  // in_ready is gated by rst directly so it drops the moment reset is asserted.
  assign in_ready = !rst && ((state_q == S_LOAD_A) || (state_q == S_LOAD_B));
  assign in_xfer  = in_valid && in_ready;
  assign res_xfer = res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    res_data_d  = res_data_q;
    res_cout_d  = res_cout_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_LOAD_A: begin
        if (in_xfer) begin
          add_a_d = in_data;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (in_xfer) begin
          add_b_d   = in_data;
          add_cin_d = in_cin;
          timer_d   = LAT;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (timer_q == 4'd0) begin
          res_data_d  = add_sum;
          res_cout_d  = add_cout;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_RESULT: begin
        if (res_xfer) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = S_LOAD_A;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      timer_q     <= 4'd0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign res_valid = res_valid_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q == S_EXEC) || (state_q == S_RESULT);

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: one combinational-adder instance (index 0) and one
// 3-cycle registered-adder instance (index 1), checked against a plain arithmetic model.
module tb_adder_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       in_cin    [2];
  logic [7:0] add_a     [2];
  logic [7:0] add_b     [2];
  logic       add_cin   [2];
  logic [7:0] add_sum   [2];
  logic       add_cout  [2];
  logic [7:0] res_data  [2];
  logic       res_cout  [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [7:0] op_count  [2];
  logic       busy      [2];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int opc   [2];
  int lat_of[2];
  logic [8:0] pipe [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_operand_sequencer #(.WIDTH(8), .ADD_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_cin(in_cin[0]),
    .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
    .add_sum(add_sum[0]), .add_cout(add_cout[0]),
    .res_data(res_data[0]), .res_cout(res_cout[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .op_count(op_count[0]), .busy(busy[0])
  );

  adder_operand_sequencer #(.WIDTH(8), .ADD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_cin(in_cin[1]),
    .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
    .add_sum(add_sum[1]), .add_cout(add_cout[1]),
    .res_data(res_data[1]), .res_cout(res_cout[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .op_count(op_count[1]), .busy(busy[1])
  );

  // Stub adders: instance 0 combinational, instance 1 delayed by three registers.
  assign {add_cout[0], add_sum[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]} + 9'(add_cin[0]);
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a[1]} + {1'b0, add_b[1]} + 9'(add_cin[1]);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign {add_cout[1], add_sum[1]} = pipe[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] v, input logic c);
    int n = 0;
    in_data[d] = v; in_cin[d] = c; in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 20) begin tick(); n++; end
    if (!in_ready[d]) chk("send_timeout", 0, 1);
    tick();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_res(input int d, output int lat);
    lat = 0;
    while (!res_valid[d] && lat < 40) begin tick(); lat++; end
    if (!res_valid[d]) chk("res_timeout", 0, 1);
  endtask

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int gap, input int stall, input bit keep);
    logic [8:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + 9'(c);
    send(d, a, 1'b0);
    repeat (gap) begin
      tick();
      chk("hold_in_load_b", in_ready[d], 1);
    end
    send(d, b, c);
    chk("busy_exec", busy[d], 1);
    chk("in_ready_exec", in_ready[d], 0);
    wait_res(d, lat);
    chk("latency", lat, lat_of[d] + 1);
    chk("add_a", add_a[d], a);
    chk("add_b", add_b[d], b);
    chk("add_cin", add_cin[d], c);
    chk("res_data", res_data[d], exp[7:0]);
    chk("res_cout", res_cout[d], exp[8]);
    repeat (stall) begin
      tick();
      chk("res_hold", {res_valid[d], res_data[d]}, {1'b1, exp[7:0]});
    end
    res_ready[d] = 1'b1;
    tick();
    if (!keep) res_ready[d] = 1'b0;
    opc[d] = (opc[d] + 1) % 256;
    chk("op_count", op_count[d], opc[d]);
    chk("res_valid_clr", res_valid[d], 0);
  endtask

  initial begin
    int t0;
    lat_of[0] = 0; lat_of[1] = 3;
    for (int d = 0; d < 2; d++) begin
      in_data[d] = '0; in_valid[d] = 0; in_cin[d] = 0; res_ready[d] = 0; opc[d] = 0;
    end
    for (int i = 0; i < 3; i++) pipe[i] = '0;

    // Reset state
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", in_ready[d], 0);
      chk("rst_outs", {add_a[d], add_b[d], add_cin[d], res_data[d], res_cout[d], res_valid[d], busy[d]}, 0);
      chk("rst_op_count", op_count[d], 0);
    end
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready[0], 1);

    // Basic combinational-adder cases
    do_op(0, 8'h25, 8'h13, 1'b0, 0, 0, 0);
    do_op(0, 8'hFF, 8'h01, 1'b1, 0, 0, 0);

    // Result stall with in_valid pulsed during it
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = i[0] ? 1'b0 : 1'b1;
      in_data[0]  = 8'($urandom);
      chk("stall_valid", res_valid[0], 1);
      chk("stall_data", {res_cout[0], res_data[0]}, 9'h033);
      chk("stall_in_ready", in_ready[0], 0);
      tick();
    end
    in_valid[0] = 1'b0;
    res_ready[0] = 1'b1;
    tick();
    res_ready[0] = 1'b0;
    opc[0]++;
    chk("stall_op_count", op_count[0], opc[0]);
    do_op(0, 8'h05, 8'h06, 1'b0, 0, 0, 0);

    // Latency-3 adder
    do_op(1, 8'h80, 8'h80, 1'b0, 0, 0, 0);

    // Reset in the middle of EXEC aborts the operation
    send(1, 8'h3C, 1'b0);
    send(1, 8'h4D, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready[1], 0);
    chk("midrst_outs", {add_a[1], add_b[1], add_cin[1], res_data[1], res_cout[1], res_valid[1], busy[1]}, 0);
    chk("midrst_op_count", op_count[1], 0);
    opc[0] = 0; opc[1] = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", in_ready[1], 1);
    repeat (6) tick();
    chk("midrst_no_result", {res_valid[1], busy[1]}, 0);

    // Randomised ops with gaps and result stalls on the latency-3 instance
    for (int i = 0; i < 20; i++)
      do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);

    // 256 back-to-back ops: wrap and throughput of ADD_LATENCY+4 cycles each
    res_ready[0] = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 256; i++)
      do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0, 1);
    chk("b2b_cycles", cyc - t0, 256 * 4);
    chk("b2b_wrap", op_count[0], 0);
    res_ready[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
